// File: rtl/dvi_encoder.sv
// rtl/dvi_encoder.sv - three-channel TMDS encoder for a DVI transmitter
//
// dvi_tmds_channel : one TMDS lane, 8-bit pixel or 2-bit control in,
//                    10-bit symbol out, two register stages.
//   clk, reset            pixel clock, synchronous active-high reset
//   data[7:0]             pixel byte, used when de=1
//   de, c0, c1            active-video flag and control bits
//   symbol[9:0]           TMDS symbol, bit 0 transmitted first
//
// dvi_encoder      : blue/green/red lanes sharing one pipeline timing.
//   clk, reset            pixel clock, synchronous active-high reset
//   vga_r/g/b[7:0]        pixel colour, valid when vga_de=1
//   vga_hs, vga_vs        sync levels, passed to the blue lane unmodified
//   vga_de                1 = active video, 0 = blanking
//   tmds_r/g/b[9:0]       TMDS symbols, bit 0 transmitted first
//
// Build option: DVI_INPUT_REG_EN adds an input register stage in front of
// the lanes, raising latency from 2 to 3 clocks.

module dvi_tmds_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    output logic [9:0] symbol
);
    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    // Stage 1: transition-minimising pre-code
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m_next;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, data[i]};
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        q_m_next = '0;
        q_m_next[0] = data[0];
        for (int i = 1; i < 8; i++)
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
        // q_m[8] records which chain was used so the receiver can undo it
        q_m_next[8] = ~use_xnor;
    end

    logic [8:0] q_m;
    logic       de_s1;
    logic       c0_s1;
    logic       c1_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_m   <= '0;
            de_s1 <= 1'b0;
            c0_s1 <= 1'b0;
            c1_s1 <= 1'b0;
        end else begin
            q_m   <= q_m_next;
            de_s1 <= de;
            c0_s1 <= c0;
            c1_s1 <= c1;
        end
    end

    // Stage 2: DC balancing against the running disparity cnt
    logic [3:0]        n1q;
    logic [3:0]        n0q;
    logic signed [5:0] diff;
    logic signed [5:0] cnt;
    logic signed [5:0] cnt_next;
    logic [9:0]        symbol_next;

    always_comb begin
        n1q = '0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q_m[i]};
        n0q  = 4'd8 - n1q;
        diff = $signed({2'b00, n1q}) - $signed({2'b00, n0q});
        symbol_next = CTL_00;
        cnt_next    = '0;
        if (!de_s1) begin
            case ({c1_s1, c0_s1})
                2'b00:   symbol_next = CTL_00;
                2'b01:   symbol_next = CTL_01;
                2'b10:   symbol_next = CTL_10;
                default: symbol_next = CTL_11;
            endcase
            cnt_next = '0;
        end else if ((cnt == 6'sd0) || (n1q == n0q)) begin
            symbol_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_next    = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if ((!cnt[5] && (n1q > n0q)) || (cnt[5] && (n0q > n1q))) begin
            // cnt is non-zero here, so a clear sign bit means cnt > 0
            symbol_next = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next    = cnt - diff + (q_m[8] ? 6'sd2 : 6'sd0);
        end else begin
            symbol_next = {1'b0, q_m[8], q_m[7:0]};
            cnt_next    = cnt + diff - (q_m[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            symbol <= CTL_00;
            cnt    <= '0;
        end else begin
            symbol <= symbol_next;
            cnt    <= cnt_next;
        end
    end
endmodule

module dvi_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] vga_r,
    input  logic [7:0] vga_g,
    input  logic [7:0] vga_b,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_de,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       hs_in;
    logic       vs_in;
    logic       de_in;

`ifdef DVI_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in  <= '0;
            g_in  <= '0;
            b_in  <= '0;
            hs_in <= 1'b0;
            vs_in <= 1'b0;
            de_in <= 1'b0;
        end else begin
            r_in  <= vga_r;
            g_in  <= vga_g;
            b_in  <= vga_b;
            hs_in <= vga_hs;
            vs_in <= vga_vs;
            de_in <= vga_de;
        end
    end
`else
    assign r_in  = vga_r;
    assign g_in  = vga_g;
    assign b_in  = vga_b;
    assign hs_in = vga_hs;
    assign vs_in = vga_vs;
    assign de_in = vga_de;
`endif

    dvi_tmds_channel u_blue (
        .clk    (clk),
        .reset  (reset),
        .data   (b_in),
        .de     (de_in),
        .c0     (hs_in),
        .c1     (vs_in),
        .symbol (tmds_b)
    );

    dvi_tmds_channel u_green (
        .clk    (clk),
        .reset  (reset),
        .data   (g_in),
        .de     (de_in),
        .c0     (1'b0),
        .c1     (1'b0),
        .symbol (tmds_g)
    );

    dvi_tmds_channel u_red (
        .clk    (clk),
        .reset  (reset),
        .data   (r_in),
        .de     (de_in),
        .c0     (1'b0),
        .c1     (1'b0),
        .symbol (tmds_r)
    );
endmodule

// File: tb/tb_dvi_encoder.sv
// tb/tb_dvi_encoder.sv - directed and random-stream bench for dvi_encoder
module tb_dvi_encoder;
`ifdef DVI_INPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [9:0] CTL_00   = 10'b1101010100;
    localparam logic [9:0] CTL_01   = 10'b0010101011;
    localparam logic [9:0] CTL_10   = 10'b0101010100;
    localparam logic [9:0] CTL_11   = 10'b1010101011;
    localparam logic [9:0] SYM_ZA   = 10'b0100000000;
    localparam logic [9:0] SYM_ONES = 10'b1111111111;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de;
    logic [9:0] tmds_r, tmds_g, tmds_b;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]        sym_now [3];
    logic signed [5:0] cnt_now [3];

    dvi_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .vga_r  (vga_r),
        .vga_g  (vga_g),
        .vga_b  (vga_b),
        .vga_hs (vga_hs),
        .vga_vs (vga_vs),
        .vga_de (vga_de),
        .tmds_r (tmds_r),
        .tmds_g (tmds_g),
        .tmds_b (tmds_b)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vga_de = de; vga_hs = hs; vga_vs = vs;
        vga_r = r; vga_g = g; vga_b = b;
    endtask

    // channel order everywhere: 0 = red, 1 = green, 2 = blue
    task automatic sample;
        sym_now[0] = tmds_r; sym_now[1] = tmds_g; sym_now[2] = tmds_b;
        cnt_now[0] = dut.u_red.cnt; cnt_now[1] = dut.u_green.cnt; cnt_now[2] = dut.u_blue.cnt;
    endtask

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return CTL_00;
            2'b01:   return CTL_01;
            2'b10:   return CTL_10;
            default: return CTL_11;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic test_reset;
        logic [9:0] exp_b;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample;
            for (int ch = 0; ch < 3; ch++) begin
                vectors++;
                if (sym_now[ch] !== CTL_00) begin
                    miscompares++;
                    $display("FAIL reset_sym ch%0d k=%0d: got %b want %b", ch, k, sym_now[ch], CTL_00);
                end
                vectors++;
                if (cnt_now[ch] !== 6'sd0) begin
                    miscompares++;
                    $display("FAIL reset_cnt ch%0d k=%0d: got %0d want 0", ch, k, cnt_now[ch]);
                end
            end
        end
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            exp_b = (k == LAT) ? CTL_11 : CTL_00;
            vectors++;
            if (tmds_b !== exp_b) begin
                miscompares++;
                $display("FAIL release_b k=%0d: got %b want %b", k, tmds_b, exp_b);
            end
            vectors++;
            if (tmds_g !== CTL_00 || tmds_r !== CTL_00) begin
                miscompares++;
                $display("FAIL release_rg k=%0d: got %b/%b want %b", k, tmds_r, tmds_g, CTL_00);
            end
        end
    endtask

    task automatic test_zero_pixels;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            sample;
            for (int ch = 0; ch < 3; ch++) begin
                if (k == LAT || k == LAT + 1) begin
                    vectors++;
                    if (sym_now[ch] !== ((k == LAT) ? SYM_ZA : SYM_ONES)) begin
                        miscompares++;
                        $display("FAIL zero_sym ch%0d k=%0d: got %b want %b", ch, k, sym_now[ch],
                                 (k == LAT) ? SYM_ZA : SYM_ONES);
                    end
                    vectors++;
                    if (cnt_now[ch] !== ((k == LAT) ? -6'sd8 : 6'sd2)) begin
                        miscompares++;
                        $display("FAIL zero_cnt ch%0d k=%0d: got %0d want %0d", ch, k, cnt_now[ch],
                                 (k == LAT) ? -8 : 2);
                    end
                end
                if (k == LAT + 2) begin
                    vectors++;
                    if (sym_now[ch] !== ((ch == 2) ? CTL_11 : CTL_00) || cnt_now[ch] !== 6'sd0) begin
                        miscompares++;
                        $display("FAIL zero_blank ch%0d: got %b cnt %0d want %b cnt 0", ch, sym_now[ch],
                                 cnt_now[ch], (ch == 2) ? CTL_11 : CTL_00);
                    end
                end
            end
            if (k == 2) drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic test_ff_blue;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            sample;
            if (k == LAT) begin
                vectors++;
                if (tmds_b !== 10'b1000000000 || cnt_now[2] !== -6'sd8) begin
                    miscompares++;
                    $display("FAIL ff_blue: got %b cnt %0d want 1000000000 cnt -8", tmds_b, cnt_now[2]);
                end
                vectors++;
                if (tmds_r !== SYM_ZA || tmds_g !== SYM_ZA) begin
                    miscompares++;
                    $display("FAIL ff_rg: got %b/%b want %b", tmds_r, tmds_g, SYM_ZA);
                end
            end
            if (k == LAT + 1) begin
                vectors++;
                if (tmds_b !== CTL_11 || cnt_now[2] !== 6'sd0) begin
                    miscompares++;
                    $display("FAIL ff_blank: got %b cnt %0d want %b cnt 0", tmds_b, cnt_now[2], CTL_11);
                end
            end
            if (k == 1) drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic test_disparity_cases;
        logic [7:0]        g_dat [4];
        logic [9:0]        g_exp [4];
        logic signed [5:0] g_cnt [4];
        logic [9:0]        z_exp [4];
        logic signed [5:0] z_cnt [4];
        int idx;
        g_dat = '{8'h0F, 8'hF0, 8'h00, 8'hFF};
        g_exp = '{10'b0100000101, 10'b0011111010, 10'b1111111111, 10'b1000000000};
        g_cnt = '{-6'sd4, -6'sd2, 6'sd8, 6'sd0};
        z_exp = '{SYM_ZA, SYM_ONES, SYM_ZA, SYM_ONES};
        z_cnt = '{-6'sd8, 6'sd2, -6'sd6, 6'sd4};
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        for (int k = 0; k <= LAT + 4; k++) begin
            if (k > 0) @(negedge clk);
            sample;
            if (k >= LAT && k < LAT + 4) begin
                idx = k - LAT;
                vectors++;
                if (sym_now[1] !== g_exp[idx] || cnt_now[1] !== g_cnt[idx]) begin
                    miscompares++;
                    $display("FAIL disp_g #%0d: got %b cnt %0d want %b cnt %0d", idx, sym_now[1],
                             cnt_now[1], g_exp[idx], g_cnt[idx]);
                end
                for (int ch = 0; ch < 3; ch += 2) begin
                    vectors++;
                    if (sym_now[ch] !== z_exp[idx] || cnt_now[ch] !== z_cnt[idx]) begin
                        miscompares++;
                        $display("FAIL disp_zero ch%0d #%0d: got %b cnt %0d want %b cnt %0d", ch, idx,
                                 sym_now[ch], cnt_now[ch], z_exp[idx], z_cnt[idx]);
                    end
                end
            end
            if (k == LAT + 4) begin
                vectors++;
                if (tmds_b !== CTL_11 || cnt_now[1] !== 6'sd0) begin
                    miscompares++;
                    $display("FAIL disp_blank: got %b cnt_g %0d want %b cnt 0", tmds_b, cnt_now[1], CTL_11);
                end
            end
            if (k < 4) drive(1'b1, 1'b1, 1'b1, 8'h00, g_dat[k], 8'h00);
            else drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic test_random_stream;
        pix_t       hist[$];
        pix_t       p;
        pix_t       e;
        int         disp [3];
        logic [7:0] dat;
        logic [9:0] ctl;
        disp = '{0, 0, 0};
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (hist.size() == LAT) begin
                e = hist.pop_front();
                sample;
                for (int ch = 0; ch < 3; ch++) begin
                    dat = (ch == 0) ? e.r : ((ch == 1) ? e.g : e.b);
                    ctl = (ch == 2) ? ctl_sym({e.vs, e.hs}) : CTL_00;
                    if (e.de) begin
                        vectors++;
                        if (tmds_decode(sym_now[ch]) !== dat) begin
                            miscompares++;
                            $display("FAIL rand_decode ch%0d cyc %0d: got %h (sym %b) want %h", ch, i,
                                     tmds_decode(sym_now[ch]), sym_now[ch], dat);
                        end
                        disp[ch] = disp[ch] + 2 * $countones(sym_now[ch]) - 10;
                        vectors++;
                        if (int'(cnt_now[ch]) !== disp[ch]) begin
                            miscompares++;
                            $display("FAIL rand_cnt ch%0d cyc %0d: got %0d want %0d", ch, i, cnt_now[ch], disp[ch]);
                        end
                        vectors++;
                        if (int'(cnt_now[ch]) > 10 || int'(cnt_now[ch]) < -10) begin
                            miscompares++;
                            $display("FAIL rand_bound ch%0d cyc %0d: got %0d want |cnt|<=10", ch, i, cnt_now[ch]);
                        end
                    end else begin
                        disp[ch] = 0;
                        vectors++;
                        if (sym_now[ch] !== ctl || cnt_now[ch] !== 6'sd0) begin
                            miscompares++;
                            $display("FAIL rand_ctl ch%0d cyc %0d: got %b cnt %0d want %b cnt 0", ch, i,
                                     sym_now[ch], cnt_now[ch], ctl);
                        end
                    end
                end
            end
            p.de = ((i / 640) % 2) == 1;
            p.hs = 1'($urandom);
            p.vs = 1'($urandom);
            p.r  = 8'($urandom);
            p.g  = 8'($urandom);
            p.b  = 8'($urandom);
            drive(p.de, p.hs, p.vs, p.r, p.g, p.b);
            hist.push_back(p);
        end
    endtask

    task automatic test_mid_line_reset;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sample;
            for (int ch = 0; ch < 3; ch++) begin
                vectors++;
                if (sym_now[ch] !== CTL_00 || cnt_now[ch] !== 6'sd0) begin
                    miscompares++;
                    $display("FAIL midreset ch%0d k=%0d: got %b cnt %0d want %b cnt 0", ch, k,
                             sym_now[ch], cnt_now[ch], CTL_00);
                end
            end
        end
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            sample;
            for (int ch = 0; ch < 3; ch++) begin
                vectors++;
                if (k < LAT && sym_now[ch] !== CTL_00) begin
                    miscompares++;
                    $display("FAIL postreset_hold ch%0d k=%0d: got %b want %b", ch, k, sym_now[ch], CTL_00);
                end else if (k == LAT && (sym_now[ch] !== SYM_ZA || cnt_now[ch] !== -6'sd8)) begin
                    miscompares++;
                    $display("FAIL postreset_first ch%0d: got %b cnt %0d want %b cnt -8", ch, sym_now[ch],
                             cnt_now[ch], SYM_ZA);
                end else if (k == LAT + 1 && (sym_now[ch] !== SYM_ONES || cnt_now[ch] !== 6'sd2)) begin
                    miscompares++;
                    $display("FAIL postreset_second ch%0d: got %b cnt %0d want %b cnt 2", ch, sym_now[ch],
                             cnt_now[ch], SYM_ONES);
                end
            end
        end
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (LAT + 1) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        test_reset;
        test_zero_pixels;
        test_ff_blue;
        test_disparity_cases;
        test_random_stream;
        test_mid_line_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
